mant_mul_arbiter: RTL and testbench

//  Shares one pipelined 11x11 mantissa multiplier (wallace_tree) among N_REQ fp16 requesters
//  (vertex-shader lanes). Per-requester valid/ready issue, round-robin, one accept per cycle.
//  Tag pipeline matched to multiplier latency routes each 22-bit product back to its requester.

---
 rtl/mant_mul_arbiter_pkg.sv | 19 +
 rtl/mant_mul_arbiter_if.sv | 25 ++
 rtl/mant_mul_arbiter_rr_arbiter.sv | 38 +++
 rtl/mant_mul_arbiter.sv | 99 +++++++++
 tb/tb_mant_mul_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mant_mul_arbiter_pkg.sv
// Shared constants and types for the mantissa-multiplier arbiter.
// Tag ids are carried at a fixed width; only the low id_width(N_REQ) bits are ever non-zero.
package mant_mul_arbiter_pkg;

  localparam int unsigned MANT_W   = 11;
  localparam int unsigned PROD_W   = 2 * MANT_W;
  localparam int unsigned ID_MAX_W = 3;  // enough for up to 8 requesters

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  // Requester id width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mant_mul_arbiter_if.sv
// Requester-side issue/response bundle of the mantissa-multiplier arbiter.
// Operands are packed per requester: requester i at [i*MANT_W +: MANT_W].
interface mant_mul_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned MANT_W = 11
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*MANT_W-1:0] req_a;
  logic [N_REQ*MANT_W-1:0] req_b;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [2*MANT_W-1:0]     rsp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/mant_mul_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping at N.
// Works for non-power-of-2 N; ptr must be below N.
module mant_mul_arbiter_rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_valid
);

  logic [N-1:0] rot;
  logic [IDW:0] sum;

  // Rotate so bit k is the requester k places after ptr.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    sum       = '0;
    gnt_valid = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum       = {1'b0, ptr} + (IDW+1)'(k);
        gnt_valid = 1'b1;
      end
    end
    if (sum >= (IDW+1)'(N)) begin
      sum = sum - (IDW+1)'(N);
    end
    gnt_idx = sum[IDW-1:0];
    for (int i = 0; i < int'(N); i++) begin
      gnt[i] = gnt_valid && (gnt_idx == IDW'(i));
    end
  end

endmodule

// File: rtl/mant_mul_arbiter.sv
// Shares one pipelined mantissa multiplier among N_REQ requesters with round-robin issue;
// a tag pipe matched to MUL_LAT routes each product back to its requester as a one-cycle pulse.
module mant_mul_arbiter
  import mant_mul_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  mant_mul_arbiter_if.slave bus,
  output logic [MANT_W-1:0] mul_a,
  output logic [MANT_W-1:0] mul_b,
  input  logic [PROD_W-1:0] mul_out,
  output logic              busy
);

  localparam int unsigned IDW = id_width(N_REQ);
  // MUL_LAT+1 stages track the operand register and the multiplier, plus the output stage.
  localparam int unsigned NST = MUL_LAT + 2;

  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    rr_ptr_d;
  logic [N_REQ-1:0]  gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_valid;
  logic [MANT_W-1:0] a_sel;
  logic [MANT_W-1:0] b_sel;
  tag_t              tag_q [NST];
  logic [PROD_W-1:0] rsp_data_q;

  mant_mul_arbiter_rr_arbiter #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_rr_arbiter (
    .req       (bus.req_valid & {N_REQ{en}}),
    .ptr       (rr_ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) begin
        a_sel = bus.req_a[i*MANT_W +: MANT_W];
        b_sel = bus.req_b[i*MANT_W +: MANT_W];
      end
    end
  end

  assign rr_ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_data_q <= '0;
      for (int s = 0; s < int'(NST); s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      if (gnt_valid) begin
        rr_ptr_q <= rr_ptr_d;
      end
      // a_sel/b_sel are zero when nothing is granted, which idles the multiplier inputs.
      mul_a          <= a_sel;
      mul_b          <= b_sel;
      tag_q[0].valid <= gnt_valid;
      tag_q[0].id    <= ID_MAX_W'(gnt_idx);
      for (int s = 1; s < int'(NST); s++) begin
        tag_q[s] <= tag_q[s-1];
      end
      rsp_data_q <= mul_out;
    end
  end

  assign bus.rsp_data = rsp_data_q;

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      bus.rsp_valid[i] = tag_q[NST-1].valid && (tag_q[NST-1].id == ID_MAX_W'(i));
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < int'(NST); s++) begin
      busy = busy | tag_q[s].valid;
    end
  end

endmodule

// File: tb/tb_mant_mul_arbiter.sv
// Directed bench for mant_mul_arbiter: a 4-requester and a 3-requester instance, each fed by a
// one-cycle behavioural multiplier, checked against hand-computed grants and products.
module tb_mant_mul_arbiter;

  localparam int unsigned MW = 11;
  localparam int unsigned PW = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en4 = 1'b1;
  logic en3 = 1'b1;

  logic [MW-1:0] mul_a4, mul_b4, mul_a3, mul_b3;
  logic [PW-1:0] mul_out4, mul_out3;
  logic          busy4, busy3;

  int n_tests = 0;
  int n_fail  = 0;

  mant_mul_arbiter_if #(.N_REQ(4), .MANT_W(MW)) bus4 ();
  mant_mul_arbiter_if #(.N_REQ(3), .MANT_W(MW)) bus3 ();

  mant_mul_arbiter #(.N_REQ(4), .MUL_LAT(1)) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .en      (en4),
    .bus     (bus4),
    .mul_a   (mul_a4),
    .mul_b   (mul_b4),
    .mul_out (mul_out4),
    .busy    (busy4)
  );

  mant_mul_arbiter #(.N_REQ(3), .MUL_LAT(1)) u_dut3 (
    .clk     (clk),
    .rst     (rst),
    .en      (en3),
    .bus     (bus3),
    .mul_a   (mul_a3),
    .mul_b   (mul_b3),
    .mul_out (mul_out3),
    .busy    (busy3)
  );

  // Stand-in for the single-stage multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_out4 <= '0;
      mul_out3 <= '0;
    end else begin
      mul_out4 <= PW'(mul_a4) * PW'(mul_b4);
      mul_out3 <= PW'(mul_a3) * PW'(mul_b3);
    end
  end

  always #5 clk = ~clk;

  logic [MW-1:0] opa [4];
  logic [MW-1:0] opb [4];
  logic [PW-1:0] prod [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus4.req_valid = '0;
    bus3.req_valid = '0;
    en4 = 1'b1;
    en3 = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++; if (bus4.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b exp 0000", bus4.req_ready); end
    n_tests++; if (bus4.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0000", bus4.rsp_valid); end
    n_tests++; if (bus4.rsp_data !== 22'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %0d exp 0", bus4.rsp_data); end
    n_tests++; if (mul_a4 !== 11'd0 || mul_b4 !== 11'd0) begin n_fail++; $display("FAIL reset_mul_ab: got %0d/%0d exp 0/0", mul_a4, mul_b4); end
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy4); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus4.req_a = {11'd0, 11'd0, 11'd0, 11'd1894};
    bus4.req_b = {11'd0, 11'd0, 11'd0, 11'd1062};
    bus4.req_valid = 4'b0001;
    #1;
    n_tests++; if (bus4.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b exp 0001", bus4.req_ready); end
    step();
    bus4.req_valid = 4'b0000;
    n_tests++; if (mul_a4 !== 11'd1894 || mul_b4 !== 11'd1062) begin n_fail++; $display("FAIL single_mul_ab: got %0d/%0d exp 1894/1062", mul_a4, mul_b4); end
    n_tests++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", busy4); end
    step();
    n_tests++; if (bus4.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early: got %b exp 0000", bus4.rsp_valid); end
    step();
    n_tests++; if (bus4.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b exp 0001", bus4.rsp_valid); end
    n_tests++; if (bus4.rsp_data !== 22'd2011428) begin n_fail++; $display("FAIL single_rsp_data: got %0d exp 2011428", bus4.rsp_data); end
    step();
    n_tests++; if (bus4.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_end: got %b exp 0000", bus4.rsp_valid); end
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b exp 0", busy4); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int k;
    do_reset();
    bus4.req_a = {opa[3], opa[2], opa[1], opa[0]};
    bus4.req_b = {opb[3], opb[2], opb[1], opb[0]};
    bus4.req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) bus4.req_valid = 4'b0000;
      #1;
      exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      n_tests++; if (bus4.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b exp %b", c, bus4.req_ready, exp_rdy); end
      step();
      if (c >= 2) begin
        k = (c - 2) % 4;
        n_tests++; if (bus4.rsp_valid !== 4'(1 << k) || bus4.rsp_data !== prod[k]) begin
          n_fail++; $display("FAIL rr_rsp[%0d]: got %b/%0d exp %b/%0d", c, bus4.rsp_valid, bus4.rsp_data, 4'(1 << k), prod[k]);
        end
      end
    end
    n_tests++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL rr_busy_tail: got %b exp 1", busy4); end
    step();
    n_tests++; if (busy4 !== 1'b0 || bus4.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rr_drain: got %b/%b exp 0/0000", busy4, bus4.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus4.req_a = {11'd0, 11'd190, 11'd0, 11'd0};
    bus4.req_b = {11'd0, 11'd162, 11'd0, 11'd0};
    bus4.req_valid = 4'b0100;
    #1;
    n_tests++; if (bus4.req_ready !== 4'b0100) begin n_fail++; $display("FAIL b2b_ready0: got %b exp 0100", bus4.req_ready); end
    step();
    bus4.req_a = {11'd0, 11'd2047, 11'd0, 11'd0};
    bus4.req_b = {11'd0, 11'd2047, 11'd0, 11'd0};
    #1;
    n_tests++; if (bus4.req_ready !== 4'b0100) begin n_fail++; $display("FAIL b2b_ready1: got %b exp 0100", bus4.req_ready); end
    step();
    bus4.req_valid = 4'b0000;
    step();
    n_tests++; if (bus4.rsp_valid !== 4'b0100 || bus4.rsp_data !== 22'd30780) begin n_fail++; $display("FAIL b2b_rsp0: got %b/%0d exp 0100/30780", bus4.rsp_valid, bus4.rsp_data); end
    step();
    n_tests++; if (bus4.rsp_valid !== 4'b0100 || bus4.rsp_data !== 22'd4190209) begin n_fail++; $display("FAIL b2b_rsp1: got %b/%0d exp 0100/4190209", bus4.rsp_valid, bus4.rsp_data); end
    step();
    n_tests++; if (bus4.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL b2b_end: got %b exp 0000", bus4.rsp_valid); end
  endtask

  task automatic test_enable();
    do_reset();
    bus4.req_a = {opa[3], opa[2], opa[1], opa[0]};
    bus4.req_b = {opb[3], opb[2], opb[1], opb[0]};
    bus4.req_valid = 4'b1111;
    #1;
    n_tests++; if (bus4.req_ready !== 4'b0001) begin n_fail++; $display("FAIL en_ready_on: got %b exp 0001", bus4.req_ready); end
    step();
    en4 = 1'b0;
    #1;
    n_tests++; if (bus4.req_ready !== 4'b0000) begin n_fail++; $display("FAIL en_ready_off: got %b exp 0000", bus4.req_ready); end
    step();
    n_tests++; if (busy4 !== 1'b1 || mul_a4 !== 11'd0) begin n_fail++; $display("FAIL en_inflight: got busy %b mul_a %0d exp 1/0", busy4, mul_a4); end
    step();
    n_tests++; if (bus4.rsp_valid !== 4'b0001 || bus4.rsp_data !== prod[0]) begin n_fail++; $display("FAIL en_drain_rsp: got %b/%0d exp 0001/%0d", bus4.rsp_valid, bus4.rsp_data, prod[0]); end
    step();
    n_tests++; if (busy4 !== 1'b0 || bus4.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL en_busy_fall: got %b/%b exp 0/0000", busy4, bus4.rsp_valid); end
    bus4.req_valid = 4'b0000;
    en4 = 1'b1;
  endtask

  task automatic test_reset_midop();
    do_reset();
    bus4.req_a = {11'd2047, 11'd0, 11'd0, 11'd0};
    bus4.req_b = {11'd2, 11'd0, 11'd0, 11'd0};
    bus4.req_valid = 4'b1000;
    step();
    bus4.req_valid = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (bus4.rsp_valid !== 4'b0000 || bus4.rsp_data !== 22'd0 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got %b/%0d/%b exp 0000/0/0", bus4.rsp_valid, bus4.rsp_data, busy4);
    end
    n_tests++; if (mul_a4 !== 11'd0 || mul_b4 !== 11'd0 || bus4.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_mul: got %0d/%0d/%b exp 0/0/0000", mul_a4, mul_b4, bus4.req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++; if (bus4.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_no_rsp[%0d]: got %b exp 0000", c, bus4.rsp_valid); end
    end
  endtask

  task automatic test_n3_wrap();
    logic [2:0] seq [6];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
    seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
    do_reset();
    bus3.req_a = {11'd9, 11'd20, 11'd4};
    bus3.req_b = {11'd9, 11'd3, 11'd5};
    bus3.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests++; if (bus3.req_ready !== seq[c]) begin n_fail++; $display("FAIL n3_wrap_ready[%0d]: got %b exp %b", c, bus3.req_ready, seq[c]); end
      step();
    end
    // Accept at the third edge (requester 2) pulses after the fifth edge.
    n_tests++; if (bus3.rsp_valid !== 3'b001 || bus3.rsp_data !== 22'd20) begin n_fail++; $display("FAIL n3_rsp0: got %b/%0d exp 001/20", bus3.rsp_valid, bus3.rsp_data); end
    bus3.req_valid = 3'b000;
    step();
    n_tests++; if (bus3.rsp_valid !== 3'b010 || bus3.rsp_data !== 22'd60) begin n_fail++; $display("FAIL n3_rsp1: got %b/%0d exp 010/60", bus3.rsp_valid, bus3.rsp_data); end
    step();
    n_tests++; if (bus3.rsp_valid !== 3'b100 || bus3.rsp_data !== 22'd81) begin n_fail++; $display("FAIL n3_rsp2: got %b/%0d exp 100/81", bus3.rsp_valid, bus3.rsp_data); end
    do_reset();
    bus3.req_valid = 3'b101;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++; if (bus3.req_ready !== ((c % 2 == 0) ? 3'b001 : 3'b100)) begin
        n_fail++; $display("FAIL n3_alt_ready[%0d]: got %b exp %b", c, bus3.req_ready, (c % 2 == 0) ? 3'b001 : 3'b100);
      end
      step();
    end
    bus3.req_valid = 3'b000;
    step();
    step();
  endtask

  initial begin
    opa[0] = 11'd3;    opb[0] = 11'd5;    prod[0] = 22'd15;
    opa[1] = 11'd194;  opb[1] = 11'd1162; prod[1] = 22'd225428;
    opa[2] = 11'd100;  opb[2] = 11'd7;    prod[2] = 22'd700;
    opa[3] = 11'd2047; opb[3] = 11'd2;    prod[3] = 22'd4094;
    bus4.req_valid = '0;
    bus4.req_a = '0;
    bus4.req_b = '0;
    bus3.req_valid = '0;
    bus3.req_a = '0;
    bus3.req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_enable();
    test_reset_midop();
    test_n3_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
